fmul_sched: RTL
===============

Name: fmul_sched

Overview:
- Round-robin scheduler that shares one sequential modular multiplier (N-bit, mod p = 2^255-19, shift-and-add core) between NREQ requesters in the field-arithmetic layer.
- Arbitrates requests, latches operands, and restarts the multiplier through its active-low reset/start input.
- Waits for data-ready, applies a watchdog timeout, and returns the tagged result over a valid/ready response channel.

Parameters:
- N, 255: operand/result width.
- NREQ, 4: number of requesters (>=2).
- IDW, max(1,$clog2(NREQ)): requester tag width.
- TIMEOUT, 300: max BUSY cycles before error; must exceed multiplier latency (N+4).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request.
- req_ready  out  NREQ  one-hot grant/accept pulse.
- req_x  in  NREQ*N  operand x; requester i at bits [i*N +: N].
- req_y  in  NREQ*N  operand y, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of served requester.
- rsp_data  out  N  product mod p.
- rsp_err  out  1  timeout flag for this response.
- mul_rst_n  out  1  multiplier reset/start; low = held idle, rising edge starts.
- mul_x  out  N  multiplier operand x.
- mul_y  out  N  multiplier operand y.
- mul_prod  in  N  multiplier result.
- mul_dr  in  1  multiplier data-ready.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values (asynchronous, while rst=0):
  - state=IDLE; req_ready=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_data=0.
  - mul_rst_n=0, mul_x=0, mul_y=0, busy=0.
  - rr_ptr = NREQ-1, so requester 0 has first priority; cycle counter = 0.
- States: IDLE, LOAD, BUSY, RESP. All outputs are registered.
- IDLE:
  - mul_rst_n=0.
  - If any req_valid: pick the first set bit searching from rr_ptr+1 upward with wrap-around.
  - Pulse req_ready[g]=1 for exactly one cycle; the handshake completes in that cycle.
  - Latch req_x[g]/req_y[g] into mul_x/mul_y, latch g into rsp_id, set rr_ptr=g, go to LOAD.
  - req_ready is never asserted outside this grant cycle and never for more than one bit.
- LOAD:
  - Lasts exactly 1 cycle with mul_rst_n=0 and operands stable; clear counter; go to BUSY.
- BUSY:
  - mul_rst_n=1; counter increments each cycle.
  - mul_x/mul_y are held constant for the whole operation; the core reads operands every cycle.
  - mul_dr=1: capture mul_prod into rsp_data, rsp_err=0, go to RESP.
  - Else if counter == TIMEOUT-1: rsp_data=0, rsp_err=1, go to RESP.
  - mul_dr takes priority if both occur in the same cycle.
- RESP:
  - mul_rst_n=0 (multiplier returned to idle).
  - rsp_valid=1; rsp_id, rsp_data and rsp_err stay stable until rsp_ready=1.
  - On the accepting cycle: rsp_valid drops next cycle, state goes to IDLE.
  - No new grant in the accepting cycle; the earliest next req_ready is one cycle after it.
- Latency: the grant-to-rsp_valid gap is the multiplier latency plus 3 cycles. Measured from grant cycle T: LOAD at T+1, BUSY from T+2, capture 1 cycle after the first mul_dr=1.
- Requesters withdrawing req_valid before grant are simply not served; there is no state corruption.
- rsp_ready while rsp_valid=0 is ignored.
- Reset mid-operation (any state): immediate return to reset values. The in-flight request is dropped with no response and rr_ptr is re-initialised.
- Exactly one outstanding operation at a time; no queuing.
- Fairness: with all requesters continuously valid, the grant order is 0,1,..,NREQ-1,0,...

Test Plan:
- Req 1 only, x=3, y=5, ideal multiplier model → req_ready=4'b0010 for one cycle, mul_rst_n low for 2 cycles, then rsp_valid with rsp_id=1, rsp_data=15, rsp_err=0, gap = model latency + 3.
- Req 0, x=y=p-1 (2^255-20) → rsp_data=1, rsp_id=0.
- All four req_valid held high, 8 operations → grant order 0,1,2,3,0,1,2,3; each rsp_id matches the grant; never two req_ready bits high.
- Model holds mul_dr=0 → rsp_valid asserted TIMEOUT+2 cycles after grant, rsp_err=1, rsp_data=0; next request completes normally with rsp_err=0.
- rsp_ready held low 10 cycles after rsp_valid, with other requests pending → rsp fields stable, no req_ready, mul_rst_n=0; grant occurs one cycle after the accepting cycle.
- rst pulsed low mid-BUSY → all outputs zero immediately; no response for the dropped request; after release, a pending request from requester 2 gets granted first only if 0 and 1 are idle (priority restarts at 0).

Source files
------------

// File: rtl/fmul_sched_if.sv
// Bus bundle for fmul_sched: requester fan-in, response channel and the
// hookup to the shared sequential modular multiplier.
interface fmul_sched_if #(
    parameter int N    = 255,
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_x;
    logic [NREQ*N-1:0] req_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_data;
    logic              rsp_err;
    logic              mul_rst_n;
    logic [N-1:0]      mul_x;
    logic [N-1:0]      mul_y;
    logic [N-1:0]      mul_prod;
    logic              mul_dr;
    logic              busy;

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready, mul_prod, mul_dr,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
        output mul_rst_n, mul_x, mul_y, busy
    );

    modport master (
        output req_valid, req_x, req_y, rsp_ready, mul_prod, mul_dr,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
        input  mul_rst_n, mul_x, mul_y, busy
    );
endinterface

// File: rtl/fmul_sched.sv
// Round-robin scheduler sharing one sequential mod-p multiplier between
// NREQ requesters; tagged results with a watchdog timeout.
module fmul_sched #(
    parameter int N       = 255,
    parameter int NREQ    = 4,
    parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int TIMEOUT = 300
) (
    input logic         clk,
    input logic         rst,
    fmul_sched_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [NREQ-1:0] r_req_ready;
    logic [IDW-1:0]  r_gnt_id;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_rsp_id;
    logic [N-1:0]    r_rsp_data;
    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic            r_mul_rst_n;
    logic [N-1:0]    r_mul_x;
    logic [N-1:0]    r_mul_y;
    logic            r_busy;
    logic [CW-1:0]   r_cnt;

    logic            w_gnt_any;
    logic [IDW-1:0]  w_gnt_id;
    logic [NREQ-1:0] w_gnt_oh;
    int              w_best_d;
    logic            w_issue;
    logic            w_take;

    // Closest valid requester after r_rr_ptr, wrapping around.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_best_d  = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] &&
                ((i - int'(r_rr_ptr) - 1 + 2 * NREQ) % NREQ) < w_best_d) begin
                w_best_d  = (i - int'(r_rr_ptr) - 1 + 2 * NREQ) % NREQ;
                w_gnt_any = 1'b1;
                w_gnt_id  = IDW'(i);
            end
        end
    end

    assign w_gnt_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_gnt_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nx;
    end

    // A grant decision raises req_ready; the following cycle is the
    // handshake cycle in which operands are taken.
    always_comb begin
        w_state_nx = r_state;
        w_issue    = 1'b0;
        w_take     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|r_req_ready) begin
                    if (|(r_req_ready & bus.req_valid)) begin
                        w_take     = 1'b1;
                        w_state_nx = LOAD;
                    end
                end else begin
                    w_issue = w_gnt_any;
                end
            end
            LOAD: w_state_nx = BUSY;
            BUSY: begin
                if (bus.mul_dr || r_cnt == CW'(TIMEOUT - 1))
                    w_state_nx = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nx = IDLE;
                    w_issue    = w_gnt_any;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_ready <= '0;
            r_gnt_id    <= '0;
            r_rr_ptr    <= IDW'(NREQ - 1);
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_mul_rst_n <= 1'b0;
            r_mul_x     <= '0;
            r_mul_y     <= '0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_req_ready <= w_issue ? w_gnt_oh : '0;
            if (w_issue)
                r_gnt_id <= w_gnt_id;
            if (w_take) begin
                r_mul_x  <= bus.req_x[int'(r_gnt_id) * N +: N];
                r_mul_y  <= bus.req_y[int'(r_gnt_id) * N +: N];
                r_rsp_id <= r_gnt_id;
                r_rr_ptr <= r_gnt_id;
            end
            r_mul_rst_n <= (w_state_nx == BUSY);
            r_busy      <= (w_state_nx != IDLE);
            if (r_state == LOAD)
                r_cnt <= '0;
            else if (r_state == BUSY)
                r_cnt <= r_cnt + 1'b1;
            if (r_state == BUSY && w_state_nx == RESP) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= !bus.mul_dr;
                r_rsp_data  <= bus.mul_dr ? bus.mul_prod : '0;
            end else if (r_state == RESP && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.mul_rst_n = r_mul_rst_n;
    assign bus.mul_x     = r_mul_x;
    assign bus.mul_y     = r_mul_y;
    assign bus.busy      = r_busy;
endmodule
